apu_core_v2: RTL and testbench
==============================

Name: apu_core_v2

Overview:
- Parametrised successor to the audio processing unit: small sequential fetch/execute sequencer for audio sample processing.
- Widens the datapath, makes register count and PC width configurable, and adds SUB, arithmetic shift, hardware loop counter, HALT and a valid/ready sample output stream.
- Sits between program/sample memory (BRAM or RAM via the existing dataReady/writeAcknowledge handshake) and the audio output mixer.

Parameters:
- DATA_W, 16, register and memory data width; must be >= 16.
- ADDR_W, 32, memory address width.
- PC_W, 8, program counter width; program space is 2^PC_W instructions.
- NREGS, 4, number of general registers (power of 2, 2..16).
- FRAC_BITS, 4, fractional bits of the signed fixed-point MUL operand.
- PROGRAM_START, 0, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- dataIn  in  DATA_W  read data; instruction in bits [15:0] during fetch
- dataReady  in  1  read data valid, one-cycle pulse
- writeAcknowledge  in  1  store accepted, one-cycle pulse
- sampleReady  in  1  downstream accepts sample
- address  out  ADDR_W  memory address
- dataOut  out  DATA_W  store data
- writeEnable  out  1  store request
- readEnable  out  1  read request (fetch or LOAD)
- readRAM  out  1  1 = LOAD targets RAM, 0 = BRAM
- sampleOut  out  DATA_W  output sample
- sampleValid  out  1  sampleOut valid
- halted  out  1  core stopped by HALT

Behaviour:
- Reset is one clock domain. clk is the clock. rst is asynchronous and active-low.
- While rst is low:
  - pc = PROGRAM_START; state = FETCH; all registers, loop counter LC and flags = 0.
  - writeEnable = 0, sampleValid = 0, halted = 0, readRAM = 0.
  - readEnable = 1, since FETCH is entered immediately.
- Reset asserted mid-operation aborts any pending memory or sample transaction at once. There is no completion.
- Instruction fields: [15:12] op, [11:8] a, [7:4] b, [7:0] imm8.
  - Register index = field mod NREGS.
  - R[a] is destination and source 1.
- States:
  - FETCH: address = zero-extended pc, readEnable = 1. Hold until dataReady, then latch the instruction and go to EXEC.
  - EXEC: single-cycle ops complete here, then return to FETCH.
  - MEM: held while LOAD/STORE waits.
  - OUT_WAIT: held while OUT waits.
  - HALT: terminal until reset.
- PC:
  - pc increments by 1 when the instruction is latched and wraps modulo 2^PC_W.
  - Jump targets use R[a][PC_W-1:0].
- Ops (all arithmetic signed two's complement, results truncated to DATA_W):
  - 0 ADD: R[a] = R[a] + R[b].
  - 1 SUB: R[a] = R[a] - R[b].
  - 2 MUL: R[a] = (R[a] * R[b]) >>> FRAC_BITS, using a full 2*DATA_W product.
  - 3 LOAD: address = R[a]; R[b] = dataIn on dataReady. readRAM = 1 iff the a field maps to index 0, held for the whole request.
  - 4 STORE: address = R[a], dataOut = R[b], writeEnable = 1 until writeAcknowledge. dataReady in the same cycle also completes the store.
  - 5 JMP: pc = R[a].
  - 6 BR: conditional jump on b[1:0]: 00 less, 01 equal, 10 greater, 11 not-equal. If taken, pc = R[a].
  - 7 CMP: flags updated from signed compare of R[a] with R[b].
  - 8 SET: R[a] = sign-extended imm8.
  - 9 SHR: R[a] = R[a] >>> b (0..15).
  - A OUT: sampleOut = R[a], sampleValid = 1. Transfer completes in the cycle where sampleValid and sampleReady are both high; sampleValid drops the next cycle.
  - B SETLC: LC = R[a].
  - C LOOP: if LC != 0, then LC = LC - 1 and pc = R[a]. If LC == 0, fall through with no decrement and no underflow.
  - D HALT: halted = 1, no further fetches, all request outputs = 0.
  - E, F: NOP.
- Latency:
  - Single-cycle op: 1 fetch-complete cycle plus 1 EXEC cycle.
  - LOAD/STORE/OUT: EXEC plus N wait cycles.
- Write collisions: the LOAD destination equal to the address register is allowed; the written value wins.

Optional Feature:
- Macro APU_SATURATE_EN.
  - Defined: ADD, SUB and MUL clamp to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Undefined: these ops wrap modulo 2^DATA_W.

Test Plan:
- Reset and ADD: rst low mid-STORE → writeEnable drops immediately. After release, first fetch at address 0. Program "SET R1,100; SET R2,-30; ADD R1,R2" → R1 = 70.
- MUL: R1 = 0x0100, R2 = 0x0018 (1.5 at FRAC_BITS = 4) → R1 = 0x0180.
- LOAD/STORE with readRAM and wait states:
  - LOAD via R0 with dataReady delayed 3 cycles → readRAM = 1 throughout, destination = dataIn.
  - STORE held until writeAcknowledge.
- Loop and output: "SETLC R3 (=3); loop: OUT R1; LOOP R2" with sampleReady toggling → exactly 4 samples emitted, LC ends at 0, no underflow.
- Saturation: ADD 0x7FFF + 1 → 0x7FFF with APU_SATURATE_EN, 0x8000 without.
- BR and HALT: CMP 5,5 then BR not-equal → not taken, BR equal → taken. HALT → halted = 1 and readEnable stays 0 for 20 cycles.

Source files
------------

// File: rtl/apu_core_v2.sv
// apu_core_v2: parametrised fetch/execute sequencer for audio sample processing.
// Optional build macro APU_SATURATE_EN: ADD/SUB/MUL clamp to the signed DATA_W range instead of wrapping.
module apu_core_v2 #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 32,
  parameter int PC_W          = 8,
  parameter int NREGS         = 4,
  parameter int FRAC_BITS     = 4,
  parameter int PROGRAM_START = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              dataReady,
  input  logic              writeAcknowledge,
  input  logic              sampleReady,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataOut,
  output logic              writeEnable,
  output logic              readEnable,
  output logic              readRAM,
  output logic [DATA_W-1:0] sampleOut,
  output logic              sampleValid,
  output logic              halted
);

  localparam int IDX_W = $clog2(NREGS);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_BR    = 4'h6;
  localparam logic [3:0] OP_CMP   = 4'h7;
  localparam logic [3:0] OP_SET   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_SETLC = 4'hB;
  localparam logic [3:0] OP_LOOP  = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hD;

  typedef enum logic [2:0] {FETCH, EXEC, MEM, OUT_WAIT, HALT} stateType;

  stateType                 state, stateNext;
  logic [PC_W-1:0]          pc;
  logic [15:0]              instr;
  logic signed [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0]        loopCount;
  logic                     flagLt, flagEq, flagGt;

  logic [3:0]                 op;
  logic [IDX_W-1:0]           aIdx, bIdx;
  logic signed [DATA_W-1:0]   regA, regB, immExt;
  logic signed [2*DATA_W-1:0] wideA, wideB, sumWide, diffWide, prodWide;
  logic [PC_W-1:0]            jumpTarget;
  logic                       brTaken;

`ifdef APU_SATURATE_EN
  localparam logic signed [2*DATA_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  // Reduce an exact wide result to DATA_W: clamp when saturating, otherwise wrap.
  function automatic logic signed [DATA_W-1:0] fitResult(input logic signed [2*DATA_W-1:0] v);
`ifdef APU_SATURATE_EN
    if (v > SAT_MAX) return DATA_W'(SAT_MAX);
    if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  assign op         = instr[15:12];
  assign aIdx       = IDX_W'({1'b0, instr[11:8]} % 5'(NREGS));
  assign bIdx       = IDX_W'({1'b0, instr[7:4]} % 5'(NREGS));
  assign regA       = regs[aIdx];
  assign regB       = regs[bIdx];
  assign immExt     = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign wideA      = {{DATA_W{regA[DATA_W-1]}}, regA};
  assign wideB      = {{DATA_W{regB[DATA_W-1]}}, regB};
  assign sumWide    = wideA + wideB;
  assign diffWide   = wideA - wideB;
  assign prodWide   = (wideA * wideB) >>> FRAC_BITS;
  assign jumpTarget = regA[PC_W-1:0];

  always_comb begin
    brTaken = 1'b0;
    case (instr[5:4])
      2'b00:   brTaken = flagLt;
      2'b01:   brTaken = flagEq;
      2'b10:   brTaken = flagGt;
      default: brTaken = !flagEq;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    address     = '0;
    dataOut     = '0;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    readRAM     = 1'b0;
    sampleOut   = regA;
    sampleValid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        address    = ADDR_W'(pc);
        readEnable = 1'b1;
        if (dataReady) stateNext = EXEC;
      end
      EXEC: begin
        case (op)
          OP_LOAD, OP_STORE: stateNext = MEM;
          OP_OUT:            stateNext = OUT_WAIT;
          OP_HALT:           stateNext = HALT;
          default:           stateNext = FETCH;
        endcase
      end
      MEM: begin
        address = ADDR_W'($unsigned(regA));
        if (op == OP_LOAD) begin
          readEnable = 1'b1;
          readRAM    = (aIdx == '0);
          if (dataReady) stateNext = FETCH;
        end else begin
          writeEnable = 1'b1;
          dataOut     = regB;
          if (writeAcknowledge || dataReady) stateNext = FETCH;
        end
      end
      OUT_WAIT: begin
        sampleValid = 1'b1;
        if (sampleReady) stateNext = FETCH;
      end
      HALT:    halted = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= PC_W'(PROGRAM_START);
      instr     <= '0;
      loopCount <= '0;
      flagLt    <= 1'b0;
      flagEq    <= 1'b0;
      flagGt    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (dataReady) begin
            instr <= dataIn[15:0];
            pc    <= pc + PC_W'(1);
          end
        end
        EXEC: begin
          case (op)
            OP_ADD:   regs[aIdx] <= fitResult(sumWide);
            OP_SUB:   regs[aIdx] <= fitResult(diffWide);
            OP_MUL:   regs[aIdx] <= fitResult(prodWide);
            OP_JMP:   pc <= jumpTarget;
            OP_BR:    if (brTaken) pc <= jumpTarget;
            OP_CMP: begin
              flagLt <= (regA < regB);
              flagEq <= (regA == regB);
              flagGt <= (regA > regB);
            end
            OP_SET:   regs[aIdx] <= immExt;
            OP_SHR:   regs[aIdx] <= regA >>> instr[7:4];
            OP_SETLC: loopCount <= regA;
            OP_LOOP: begin
              // LC == 0 falls through untouched so the counter never wraps.
              if (loopCount != '0) begin
                loopCount <= loopCount - DATA_W'(1);
                pc        <= jumpTarget;
              end
            end
            default: ;
          endcase
        end
        MEM: begin
          if (op == OP_LOAD && dataReady) regs[bIdx] <= dataIn;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_core_v2.sv
// Scoreboard bench for apu_core_v2: an instruction-level model predicts bus reads, stores and samples.
module tb_apu_core_v2;
  localparam int DW = 16;
  localparam logic [15:0] HALT_W = 16'hD000;

  logic          clk;
  logic          rst;
  logic [DW-1:0] dataIn;
  logic          dataReady, writeAcknowledge, sampleReady;
  logic [31:0]   address;
  logic [DW-1:0] dataOut, sampleOut;
  logic          writeEnable, readEnable, readRAM, sampleValid, halted;

  typedef struct { longint addr; bit isRam; } rdT;
  typedef struct { longint addr; longint data; } wrT;
  rdT     expRd[$];
  wrT     expWr[$];
  longint expSmp[$];

  logic [15:0] bram [256];
  logic [15:0] ram  [256];
  int total = 0;
  int bad = 0;
  int delayMode = -1;
  bit holdAck = 0;
  int wp = 0;
  int rdWait = -1;
  int wrWait = -1;

  apu_core_v2 #(.DATA_W(DW), .ADDR_W(32), .PC_W(8), .NREGS(4), .FRAC_BITS(4), .PROGRAM_START(0)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataReady(dataReady),
    .writeAcknowledge(writeAcknowledge), .sampleReady(sampleReady),
    .address(address), .dataOut(dataOut), .writeEnable(writeEnable),
    .readEnable(readEnable), .readRAM(readRAM), .sampleOut(sampleOut),
    .sampleValid(sampleValid), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx16(input longint v);
    longint t;
    t = v & 65535;
    return (t >= 32768) ? t - 65536 : t;
  endfunction

  function automatic longint fit(input longint v);
`ifdef APU_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return sx16(v);
`endif
  endfunction

  // Instruction-set model: walks the program and records every bus event it implies.
  task automatic iss(input int maxSteps, output bit ok);
    longint r[4];
    longint lc, addr, v, imm;
    int pc, op, a, b;
    bit lt, eq, gt, isRam, take;
    logic [15:0] w;
    foreach (r[i]) r[i] = 0;
    lc = 0; pc = 0; lt = 0; eq = 0; gt = 0; ok = 0;
    for (int s = 0; s < maxSteps; s++) begin
      w = bram[pc];
      expRd.push_back('{longint'(pc), 1'b0});
      pc = (pc + 1) % 256;
      op = int'(w[15:12]);
      a  = int'(w[11:8]) % 4;
      b  = int'(w[7:4]) % 4;
      case (op)
        0: r[a] = fit(r[a] + r[b]);
        1: r[a] = fit(r[a] - r[b]);
        2: r[a] = fit((r[a] * r[b]) >>> 4);
        3: begin
          addr  = r[a] & 65535;
          isRam = (a == 0);
          expRd.push_back('{addr, isRam});
          v = isRam ? longint'(ram[addr % 256]) : longint'(bram[addr % 256]);
          r[b] = sx16(v);
        end
        4: expWr.push_back('{r[a] & 65535, r[b] & 65535});
        5: pc = int'(r[a] & 255);
        6: begin
          case (int'(w[5:4]))
            0: take = lt;
            1: take = eq;
            2: take = gt;
            default: take = !eq;
          endcase
          if (take) pc = int'(r[a] & 255);
        end
        7: begin lt = (r[a] < r[b]); eq = (r[a] == r[b]); gt = (r[a] > r[b]); end
        8: begin imm = longint'(w[7:0]); r[a] = (imm >= 128) ? imm - 256 : imm; end
        9: r[a] = r[a] >>> int'(w[7:4]);
        10: expSmp.push_back(r[a] & 65535);
        11: lc = r[a] & 65535;
        12: if (lc != 0) begin lc = lc - 1; pc = int'(r[a] & 255); end
        13: begin ok = 1; return; end
        default: ;
      endcase
    end
  endtask

  task automatic model(output bit ok);
    expRd.delete();
    expWr.delete();
    expSmp.delete();
    iss(300, ok);
  endtask

  function automatic logic [15:0] insI(input int op, input int a, input int imm);
    return {op[3:0], a[3:0], imm[7:0]};
  endfunction

  function automatic logic [15:0] insR(input int op, input int a, input int b);
    return {op[3:0], a[3:0], b[3:0], 4'h0};
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin bram[i] = HALT_W; ram[i] = '0; end
    wp = 0;
  endtask

  task automatic put(input logic [15:0] w);
    bram[wp] = w;
    wp++;
  endtask

  // Memory / sink responder: random wait states, random sampleReady.
  initial begin
    dataIn = '0; dataReady = 1'b0; writeAcknowledge = 1'b0; sampleReady = 1'b0;
    forever begin
      @(negedge clk);
      dataReady = 1'b0;
      writeAcknowledge = 1'b0;
      dataIn = DW'($urandom);
      if (rst !== 1'b1) begin
        rdWait = -1; wrWait = -1; sampleReady = 1'b0;
      end else begin
        if (readEnable) begin
          if (rdWait < 0) rdWait = (delayMode >= 0) ? delayMode : int'($urandom_range(0, 3));
          if (rdWait == 0) begin
            dataReady = 1'b1;
            dataIn = readRAM ? ram[address[7:0]] : bram[address[7:0]];
            rdWait = -1;
          end else rdWait--;
        end else rdWait = -1;
        if (writeEnable && !holdAck) begin
          if (wrWait < 0) wrWait = int'($urandom_range(0, 3));
          if (wrWait == 0) begin
            if ($urandom_range(0, 3) == 0) dataReady = 1'b1;
            else writeAcknowledge = 1'b1;
            wrWait = -1;
          end else wrWait--;
        end else wrWait = -1;
        sampleReady = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: pops expected bus events as the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        if (readEnable) begin
          if (expRd.size() == 0) check("read_extra", 64'(readEnable), 64'd0);
          else begin
            check("read_addr", 64'(address), 64'(expRd[0].addr));
            check("read_ram", 64'(readRAM), 64'(expRd[0].isRam));
            if (dataReady) void'(expRd.pop_front());
          end
        end
        if (writeEnable && (writeAcknowledge || dataReady)) begin
          if (expWr.size() == 0) check("store_extra", 64'(writeEnable), 64'd0);
          else begin
            check("store_addr", 64'(address), 64'(expWr[0].addr));
            check("store_data", 64'(dataOut), 64'(expWr[0].data));
            void'(expWr.pop_front());
          end
        end
        if (sampleValid && sampleReady) begin
          if (expSmp.size() == 0) check("sample_extra", 64'(sampleValid), 64'd0);
          else begin
            check("sample", 64'(sampleOut), 64'(expSmp[0]));
            void'(expSmp.pop_front());
          end
        end
      end
    end
  end

  task automatic runProgram(input string name);
    int cyc;
    int busy;
    @(negedge clk);
    #3 rst = 1'b1;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check({name, "_halted"}, 64'(halted), 64'd1);
    check({name, "_reads_left"}, 64'(expRd.size()), 64'd0);
    check({name, "_stores_left"}, 64'(expWr.size()), 64'd0);
    check({name, "_samples_left"}, 64'(expSmp.size()), 64'd0);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      #2;
      if (readEnable || writeEnable || sampleValid || !halted) busy++;
    end
    check({name, "_halt_quiet"}, 64'(busy), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    int cyc;
    logic [15:0] w;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_readEnable", 64'(readEnable), 64'd1);
    check("rst_address", 64'(address), 64'd0);
    check("rst_writeEnable", 64'(writeEnable), 64'd0);
    check("rst_sampleValid", 64'(sampleValid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_readRAM", 64'(readRAM), 64'd0);

    // Reset during a pending store
    clearMem();
    put(insI(8, 0, 5)); put(insI(8, 1, 9)); put(insR(4, 0, 1));
    model(ok);
    holdAck = 1;
    @(negedge clk);
    #3 rst = 1'b1;
    cyc = 0;
    while (writeEnable !== 1'b1 && cyc < 200) begin @(negedge clk); #2; cyc++; end
    repeat (3) begin @(negedge clk); #2; end
    check("store_held", 64'(writeEnable), 64'd1);
    check("store_held_addr", 64'(address), 64'd5);
    check("store_held_data", 64'(dataOut), 64'd9);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_writeEnable", 64'(writeEnable), 64'd0);
    check("abort_readEnable", 64'(readEnable), 64'd1);
    check("abort_address", 64'(address), 64'd0);
    check("abort_halted", 64'(halted), 64'd0);
    holdAck = 0;

    // SET/SET/ADD -> 70
    clearMem();
    put(insI(8, 1, 100)); put(insI(8, 2, -30)); put(insR(0, 1, 2)); put(insR(10, 1, 0));
    model(ok);
    check("add_model_sample", 64'(expSmp[0]), 64'd70);
    runProgram("add");

    // MUL 0x0100 * 1.5
    clearMem();
    put(insI(8, 1, 64)); put(insR(0, 1, 1)); put(insR(0, 1, 1));
    put(insI(8, 2, 24)); put(insR(2, 1, 2)); put(insR(10, 1, 0));
    model(ok);
    runProgram("mul");

    // LOAD via R0 (RAM) and R1 (BRAM, dest == address reg), stores, fixed 3-cycle latency
    clearMem();
    put(insI(8, 0, 32)); put(insR(3, 0, 2)); put(insI(8, 1, 48)); put(insR(3, 1, 1));
    put(insR(4, 0, 2)); put(insR(4, 1, 1)); put(insR(10, 1, 0)); put(insR(10, 2, 0));
    ram[32] = 16'h1234;
    bram[48] = 16'hBEEF;
    model(ok);
    delayMode = 3;
    runProgram("loadstore");
    delayMode = -1;

    // Hardware loop: 4 samples of 7, then LC==0 falls through to OUT R3
    clearMem();
    put(insI(8, 3, 3)); put(insR(11, 3, 0)); put(insI(8, 2, 4)); put(insI(8, 1, 7));
    put(insR(10, 1, 0)); put(insR(12, 2, 0)); put(insI(8, 2, 10)); put(insR(12, 2, 0));
    put(insR(10, 3, 0)); put(HALT_W); put(insI(8, 1, -1)); put(insR(10, 1, 0));
    model(ok);
    runProgram("loop");

    // Saturation edge: 0x7FFF, then +1
    clearMem();
    put(insI(8, 3, 64));
    repeat (8) put(insR(0, 3, 3));
    put(insI(8, 1, 1)); put(insI(8, 2, 0)); put(insR(0, 2, 3)); put(insR(1, 2, 1));
    put(insR(0, 2, 3)); put(insR(10, 2, 0)); put(insR(0, 2, 1)); put(insR(10, 2, 0));
    model(ok);
`ifdef APU_SATURATE_EN
    check("sat_model_sample", 64'(expSmp[1]), 64'h7FFF);
`else
    check("wrap_model_sample", 64'(expSmp[1]), 64'h8000);
`endif
    runProgram("sat");

    // Branches and shift
    clearMem();
    put(insI(8, 1, 5)); put(insI(8, 2, 5)); put(insR(7, 1, 2)); put(insI(8, 3, 9));
    put(insR(6, 3, 3)); put(insI(8, 0, 1)); put(insR(10, 0, 0)); put(insR(6, 3, 1));
    put(insR(10, 1, 0)); put(insI(8, 0, 2)); put(insR(10, 0, 0)); put(insI(8, 2, -4));
    put(insR(7, 2, 1)); put(insI(8, 3, 16)); put(insR(6, 3, 0)); put(insR(10, 2, 0));
    put(insI(8, 1, -64)); put(insR(9, 1, 3)); put(insR(10, 1, 0));
    model(ok);
    runProgram("branch");

    // Random programs
    for (int n = 0; n < 10; n++) begin
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        for (int i = 0; i < 256; i++) begin bram[i] = 16'($urandom); ram[i] = 16'($urandom); end
        for (int i = 0; i < 40; i++) begin
          w = 16'($urandom);
          if (w[15:12] == 4'hD && $urandom_range(0, 3) != 0) w[15:12] = 4'hE;
          bram[i] = w;
        end
        bram[255] = HALT_W;
        model(ok);
      end
      if (!ok) begin
        bram[0] = HALT_W;
        model(ok);
      end
      runProgram("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
